multicycle_ctrl_fsm: RTL and testbench

Control state machine that sequences the shared single-ALU, single-memory datapath of the multi-cycle RV32I core (subset: lw, sw, R-type, I-type ALU, beq, jal). It latches the opcode of the fetched instruction and steps through fetch, decode, execute, memory and writeback states. It drives every datapath enable and mux select, stalls on a memory ready handshake, and traps on illegal opcodes or memory timeout.

---
 rtl/multicycle_ctrl_fsm.sv | 197 +++++++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// multicycle_ctrl_fsm - control sequencer for the multi-cycle RV32I datapath
// Revision 1.0 - initial release
// ============================================================================
module multicycle_ctrl_fsm #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TO_W           = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic       instr_retired,
  output logic       trap,
  output logic [3:0] state_dbg
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] c_OP_LW  = 7'b0000011;
  localparam logic [6:0] c_OP_SW  = 7'b0100011;
  localparam logic [6:0] c_OP_R   = 7'b0110011;
  localparam logic [6:0] c_OP_I   = 7'b0010011;
  localparam logic [6:0] c_OP_BEQ = 7'b1100011;
  localparam logic [6:0] c_OP_JAL = 7'b1101111;
  localparam logic [TO_W-1:0] c_THR =
    TO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_t          state_q, state_d;
  logic [6:0]      op_q, op_d;
  logic [TO_W-1:0] wcnt_q, wcnt_d;
  logic            w_wait;
  logic            w_timeout;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    wcnt_d    = '0;
    w_wait    = (state_q == S_FETCH) || (state_q == S_MEMREAD) ||
                (state_q == S_MEMWRITE);
    // The threshold cycle is the TIMEOUT_CYCLES-th stalled cycle; a ready
    // arriving on that same cycle still completes the access.
    w_timeout = (TIMEOUT_CYCLES > 0) && w_wait && !mem_ready &&
                (wcnt_q == c_THR);
    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        op_d = op;
        case (op)
          c_OP_LW, c_OP_SW: state_d = S_MEMADR;
          c_OP_R:           state_d = S_EXECR;
          c_OP_I:           state_d = S_EXECI;
          c_OP_BEQ:         state_d = S_BEQ;
          c_OP_JAL:         state_d = S_JAL;
          default:          state_d = S_TRAP;
        endcase
      end
      S_MEMADR:   state_d = (op_q == c_OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_TRAP;
    endcase
    if (w_timeout) state_d = S_TRAP;
    if (w_wait && !mem_ready && (state_d == state_q)) wcnt_d = wcnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Outputs are held at zero for the whole of reset so no stale write escapes.
  always_comb begin
    mem_req       = 1'b0;
    PCWrite       = 1'b0;
    AdrSrc        = 1'b0;
    IRWrite       = 1'b0;
    MemWrite      = 1'b0;
    RegWrite      = 1'b0;
    ALUSrcA       = 2'b00;
    ALUSrcB       = 2'b00;
    ALUOp         = 2'b00;
    ResultSrc     = 2'b00;
    ImmSrc        = 2'b00;
    instr_retired = 1'b0;
    trap          = 1'b0;
    state_dbg     = 4'd0;
    if (!rst) begin
      state_dbg = state_q;
      case (state_q)
        S_FETCH: begin
          mem_req   = 1'b1;
          ALUSrcB   = 2'b10;
          ResultSrc = 2'b10;
          IRWrite   = mem_ready;
          PCWrite   = mem_ready;
        end
        S_DECODE: begin
          ALUSrcA = 2'b01;
          ALUSrcB = 2'b01;
          if (op == c_OP_BEQ)      ImmSrc = 2'b10;
          else if (op == c_OP_JAL) ImmSrc = 2'b11;
        end
        S_MEMADR: begin
          ALUSrcA = 2'b10;
          ALUSrcB = 2'b01;
          if (op_q == c_OP_SW) ImmSrc = 2'b01;
        end
        S_MEMREAD: begin
          mem_req = 1'b1;
          AdrSrc  = 1'b1;
        end
        S_MEMWB: begin
          ResultSrc     = 2'b01;
          RegWrite      = 1'b1;
          instr_retired = 1'b1;
        end
        S_MEMWRITE: begin
          mem_req       = 1'b1;
          AdrSrc        = 1'b1;
          MemWrite      = 1'b1;
          ImmSrc        = 2'b01;
          instr_retired = mem_ready;
        end
        S_EXECR: begin
          ALUSrcA = 2'b10;
          ALUOp   = 2'b10;
        end
        S_EXECI: begin
          ALUSrcA = 2'b10;
          ALUSrcB = 2'b01;
          ALUOp   = 2'b10;
        end
        S_ALUWB: begin
          RegWrite      = 1'b1;
          instr_retired = 1'b1;
        end
        S_BEQ: begin
          ALUSrcA       = 2'b10;
          ALUOp         = 2'b01;
          ImmSrc        = 2'b10;
          PCWrite       = zero;
          instr_retired = 1'b1;
        end
        S_JAL: begin
          ALUSrcA = 2'b01;
          ALUSrcB = 2'b10;
          PCWrite = 1'b1;
        end
        S_TRAP:  trap = 1'b1;
        default: trap = 1'b0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// tb_multicycle_ctrl_fsm - trace-based checker for the control sequencer
// Revision 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl_fsm;

  localparam int TO = 4;
  localparam logic [6:0] c_LW  = 7'b0000011;
  localparam logic [6:0] c_SW  = 7'b0100011;
  localparam logic [6:0] c_R   = 7'b0110011;
  localparam logic [6:0] c_I   = 7'b0010011;
  localparam logic [6:0] c_BEQ = 7'b1100011;
  localparam logic [6:0] c_JAL = 7'b1101111;

  typedef struct packed {
    logic [3:0] st;
    logic       req, pcw, adr, irw, mw, rw;
    logic [1:0] sa, sb, aop, rs, imm;
    logic       ret, trp;
  } ctl_t;

  typedef struct {
    logic       r;
    logic       rdy;
    logic       z;
    logic [6:0] opv;
    ctl_t       e;
    string      tag;
  } step_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [6:0] op = '0;
  logic zero = 1'b0;
  logic mem_ready = 1'b0;
  logic mem_req, PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite;
  logic [1:0] ALUSrcA, ALUSrcB, ALUOp, ResultSrc, ImmSrc;
  logic instr_retired, trap;
  logic [3:0] state_dbg;

  int vectors = 0;
  int miscompares = 0;
  step_t q[$];

  multicycle_ctrl_fsm #(.TIMEOUT_CYCLES(TO), .TO_W(3)) dut (
    .clk(clk), .rst(rst), .op(op), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
    .MemWrite(MemWrite), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc),
    .instr_retired(instr_retired), .trap(trap), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  function automatic ctl_t in_state(int s);
    ctl_t c = '0;
    c.st = 4'(s);
    return c;
  endfunction

  task automatic add(input logic r, input logic rdy, input logic z,
                     input logic [6:0] opv, input ctl_t e, input string tag);
    step_t s;
    s.r = r; s.rdy = rdy; s.z = z; s.opv = opv; s.e = e; s.tag = tag;
    q.push_back(s);
  endtask

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic logic [6:0] ro();
    return 7'($urandom);
  endfunction

  task automatic gen_reset(input int n, input logic rdy);
    for (int i = 0; i < n; i++) add(1'b1, rdy, rb(), ro(), '0, "reset");
  endtask

  task automatic gen_trap(input int n);
    ctl_t c = in_state(11);
    c.trp = 1'b1;
    for (int i = 0; i < n; i++) add(1'b0, rb(), rb(), ro(), c, "trap");
  endtask

  // A memory-facing phase: 'stall' not-ready cycles, then a ready cycle,
  // unless the stall reaches the timeout, in which case the controller traps.
  task automatic gen_mem(input ctl_t base, input ctl_t done, input int stall,
                         input string tag, output logic trapped);
    trapped = 1'b0;
    for (int i = 0; i < stall && i < TO; i++)
      add(1'b0, 1'b0, rb(), ro(), base, {tag, "_wait"});
    if (stall >= TO) begin
      trapped = 1'b1;
      gen_trap(3);
      gen_reset(2, rb());
    end else begin
      add(1'b0, 1'b1, rb(), ro(), done, tag);
    end
  endtask

  task automatic gen_fetch(input int stall, output logic trapped);
    ctl_t c = in_state(0);
    ctl_t d;
    c.req = 1'b1; c.sb = 2'b10; c.rs = 2'b10;
    d = c; d.pcw = 1'b1; d.irw = 1'b1;
    gen_mem(c, d, stall, "fetch", trapped);
  endtask

  task automatic gen_decode(input logic [6:0] opc);
    ctl_t c = in_state(1);
    c.sa = 2'b01; c.sb = 2'b01;
    c.imm = (opc == c_BEQ) ? 2'b10 : (opc == c_JAL) ? 2'b11 : 2'b00;
    add(1'b0, rb(), rb(), opc, c, "decode");
  endtask

  task automatic gen_aluwb();
    ctl_t c = in_state(8);
    c.rw = 1'b1; c.ret = 1'b1;
    add(1'b0, rb(), rb(), ro(), c, "aluwb");
  endtask

  task automatic gen_instr(input logic [6:0] opc, input int fstall,
                           input int mstall, input logic z);
    ctl_t c, d;
    logic t;
    gen_fetch(fstall, t);
    if (t) return;
    gen_decode(opc);
    case (opc)
      c_LW, c_SW: begin
        c = in_state(2); c.sa = 2'b10; c.sb = 2'b01;
        c.imm = (opc == c_SW) ? 2'b01 : 2'b00;
        add(1'b0, rb(), rb(), ro(), c, "memadr");
        if (opc == c_LW) begin
          c = in_state(3); c.req = 1'b1; c.adr = 1'b1;
          gen_mem(c, c, mstall, "memread", t);
          if (!t) begin
            c = in_state(4); c.rs = 2'b01; c.rw = 1'b1; c.ret = 1'b1;
            add(1'b0, rb(), rb(), ro(), c, "memwb");
          end
        end else begin
          c = in_state(5); c.req = 1'b1; c.adr = 1'b1; c.mw = 1'b1;
          c.imm = 2'b01;
          d = c; d.ret = 1'b1;
          gen_mem(c, d, mstall, "memwrite", t);
        end
      end
      c_R: begin
        c = in_state(6); c.sa = 2'b10; c.aop = 2'b10;
        add(1'b0, rb(), rb(), ro(), c, "execr");
        gen_aluwb();
      end
      c_I: begin
        c = in_state(7); c.sa = 2'b10; c.sb = 2'b01; c.aop = 2'b10;
        add(1'b0, rb(), rb(), ro(), c, "execi");
        gen_aluwb();
      end
      c_BEQ: begin
        c = in_state(9); c.sa = 2'b10; c.aop = 2'b01; c.imm = 2'b10;
        c.pcw = z; c.ret = 1'b1;
        add(1'b0, rb(), z, ro(), c, "beq");
      end
      c_JAL: begin
        c = in_state(10); c.sa = 2'b01; c.sb = 2'b10; c.pcw = 1'b1;
        add(1'b0, rb(), rb(), ro(), c, "jal");
        gen_aluwb();
      end
      default: begin
        gen_trap(3);
        gen_reset(2, rb());
      end
    endcase
  endtask

  task automatic run_queue();
    step_t s;
    ctl_t obs;
    while (q.size() > 0) begin
      s = q.pop_front();
      @(negedge clk);
      rst = s.r; mem_ready = s.rdy; zero = s.z; op = s.opv;
      #1;
      obs.st = state_dbg; obs.req = mem_req; obs.pcw = PCWrite;
      obs.adr = AdrSrc; obs.irw = IRWrite; obs.mw = MemWrite;
      obs.rw = RegWrite; obs.sa = ALUSrcA; obs.sb = ALUSrcB; obs.aop = ALUOp;
      obs.rs = ResultSrc; obs.imm = ImmSrc; obs.ret = instr_retired;
      obs.trp = trap;
      vectors++;
      assert (obs === s.e) else begin
        miscompares++;
        $display("FAIL %s: observed=%h expected=%h", s.tag, obs, s.e);
        $error("vector %0d (%s) differs", vectors, s.tag);
      end
    end
  endtask

  initial begin
    logic [6:0] legal [6];
    logic [6:0] opc;
    logic t;
    ctl_t c;
    legal[0] = c_LW; legal[1] = c_SW; legal[2] = c_R;
    legal[3] = c_I;  legal[4] = c_BEQ; legal[5] = c_JAL;

    gen_reset(2, 1'b1);
    gen_instr(c_R, 0, 0, 1'b0);
    gen_instr(c_LW, 0, 3, 1'b0);
    gen_instr(c_BEQ, 0, 0, 1'b1);
    gen_instr(c_BEQ, 0, 0, 1'b0);
    gen_instr(7'b1111111, 0, 0, 1'b0);
    gen_instr(c_SW, 0, 4, 1'b0);
    gen_instr(c_SW, 0, 3, 1'b0);
    gen_instr(c_JAL, 2, 0, 1'b0);
    gen_instr(c_I, 3, 0, 1'b0);
    gen_instr(c_R, 5, 0, 1'b0);
    // Reset in the middle of a load abandons it without any write.
    gen_fetch(0, t);
    gen_decode(c_LW);
    c = in_state(2); c.sa = 2'b10; c.sb = 2'b01;
    add(1'b0, rb(), rb(), ro(), c, "memadr");
    gen_reset(1, 1'b1);
    run_queue();

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        opc = ro();
        if (opc == c_LW || opc == c_SW || opc == c_R || opc == c_I ||
            opc == c_BEQ || opc == c_JAL) opc = 7'b0000000;
      end else begin
        opc = legal[$urandom_range(0, 5)];
      end
      gen_instr(opc,
                ($urandom_range(0, 9) < 8) ? $urandom_range(0, 2) : $urandom_range(3, 5),
                ($urandom_range(0, 9) < 8) ? $urandom_range(0, 2) : $urandom_range(3, 5),
                rb());
      run_queue();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
